// File: rtl/audio_beat_scheduler.sv
// Beat scheduler: shares the single tone path between background music and queued
// sound-effect clips, freezing the music beat while a clip plays.
module audio_beat_scheduler #(
    parameter int BGM_LAST = 1200,
    parameter int SFX_LEN  = 16,
    parameter int NUM_SFX  = 4
) (
    input  logic                       clk22,
    input  logic                       rst,
    input  logic                       i_bgm_en,
    input  logic [NUM_SFX-1:0]         i_sfx_req,
    output logic [11:0]                o_beat_num,
    output logic [$clog2(NUM_SFX)-1:0] o_sfx_id,
    output logic [5:0]                 o_sfx_beat,
    output logic                       o_src_sel,
    output logic                       o_mute,
    output logic                       o_sfx_done,
    output logic [NUM_SFX-1:0]         o_pending
);
    localparam int ID_W = $clog2(NUM_SFX);

    typedef enum logic [1:0] {IDLE, BGM, SFX} state_t;

    state_t               r_state, w_state_nx;
    logic                 r_bgm_s1, r_bgm_s2;
    logic [NUM_SFX-1:0]   r_req_s1, r_req_s2, r_req_s3;
    logic [NUM_SFX-1:0]   r_pending, w_pending_nx, w_rise, w_grant_mask;
    logic [11:0]          r_beat_num, w_beat_nx;
    logic [ID_W-1:0]      r_sfx_id, w_id_nx, w_winner;
    logic [5:0]           r_sfx_beat, w_sbeat_nx;
    logic                 r_src_sel, r_mute, r_sfx_done, w_done_nx, w_grant;

    assign w_rise = r_req_s2 & ~r_req_s3;

    always_comb begin
        w_winner = '0;
        for (int i = NUM_SFX - 1; i >= 0; i--) begin
            if (r_pending[i]) w_winner = ID_W'(i);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_beat_nx  = r_beat_num;
        w_id_nx    = r_sfx_id;
        w_sbeat_nx = r_sfx_beat;
        w_done_nx  = 1'b0;
        w_grant    = 1'b0;
        case (r_state)
            IDLE: begin
                w_beat_nx = '0;
                if (r_pending != '0)  w_grant    = 1'b1;
                else if (r_bgm_s2)    w_state_nx = BGM;
            end
            BGM: begin
                // The pending check wins so the beat stays frozen on the preempting edge.
                if (r_pending != '0) begin
                    w_grant = 1'b1;
                end else if (!r_bgm_s2) begin
                    w_state_nx = IDLE;
                    w_beat_nx  = '0;
                end else begin
                    w_beat_nx = (r_beat_num == 12'(BGM_LAST)) ? 12'd0 : r_beat_num + 12'd1;
                end
            end
            SFX: begin
                if (r_sfx_beat == 6'(SFX_LEN - 1)) begin
                    if (r_pending != '0) begin
                        w_grant = 1'b1;
                    end else if (r_bgm_s2) begin
                        w_state_nx = BGM;
                    end else begin
                        w_state_nx = IDLE;
                        w_beat_nx  = '0;
                    end
                end else begin
                    w_sbeat_nx = r_sfx_beat + 6'd1;
                    w_done_nx  = (r_sfx_beat + 6'd1 == 6'(SFX_LEN - 1));
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_beat_nx  = '0;
            end
        endcase
        if (w_grant) begin
            w_state_nx = SFX;
            w_id_nx    = w_winner;
            w_sbeat_nx = '0;
            w_done_nx  = (SFX_LEN == 1);
        end
    end

    // A rise on the clip being granted re-sets its bit, queueing a replay.
    assign w_grant_mask = w_grant ? ({{(NUM_SFX-1){1'b0}}, 1'b1} << w_winner) : '0;
    assign w_pending_nx = (r_pending & ~w_grant_mask) | w_rise;

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            r_bgm_s1  <= 1'b0;
            r_bgm_s2  <= 1'b0;
            r_req_s1  <= '0;
            r_req_s2  <= '0;
            r_req_s3  <= '0;
            r_pending <= '0;
        end else begin
            r_bgm_s1  <= i_bgm_en;
            r_bgm_s2  <= r_bgm_s1;
            r_req_s1  <= i_sfx_req;
            r_req_s2  <= r_req_s1;
            r_req_s3  <= r_req_s2;
            r_pending <= w_pending_nx;
        end
    end

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat_num <= '0;
            r_sfx_id   <= '0;
            r_sfx_beat <= '0;
            r_src_sel  <= 1'b0;
            r_mute     <= 1'b1;
            r_sfx_done <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_beat_num <= w_beat_nx;
            r_sfx_id   <= w_id_nx;
            r_sfx_beat <= w_sbeat_nx;
            r_src_sel  <= (w_state_nx == SFX);
            r_mute     <= (w_state_nx == IDLE);
            r_sfx_done <= w_done_nx;
        end
    end

    assign o_beat_num = r_beat_num;
    assign o_sfx_id   = r_sfx_id;
    assign o_sfx_beat = r_sfx_beat;
    assign o_src_sel  = r_src_sel;
    assign o_mute     = r_mute;
    assign o_sfx_done = r_sfx_done;
    assign o_pending  = r_pending;
endmodule
